// File: rtl/player_pkg.sv
// Shared types and defaults for the music-player playback datapath.
package player_pkg;

   localparam int BEAT_W           = 12;
   localparam int LEN_DEFAULT      = 4095;
   localparam int TICK_DIV_DEFAULT = 3125000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // Counter must reach 2*TICK_DIV-1 for slow playback.
   function automatic int cnt_width(input int tick_div);
      return $clog2(2 * tick_div);
   endfunction

endpackage

// File: rtl/beat_prescaler.sv
// Beat-period prescaler: counts while running and flags the beat boundary.
module beat_prescaler
   import player_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clr,
   input  logic slow,
   output logic hit,
   output logic tick
);

   localparam int CNT_W = cnt_width(TICK_DIV);
   localparam logic [CNT_W-1:0] THR_FAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] THR_SLOW = CNT_W'(2 * TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] threshold;

   assign threshold = slow ? THR_SLOW : THR_FAST;
   // >= lets a slow->fast switch with cnt past the fast threshold tick at once.
   assign hit       = (cnt >= threshold);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (run) begin
         if (hit) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/beat_sequencer.sv
// Playback controller producing the beat index for the note ROM.
// Optional build macro BEAT_SEQ_LOOP_EN: wrap to beat 0 at the end instead of stopping.
module beat_sequencer
   import player_pkg::*;
#(
   parameter int LEN      = LEN_DEFAULT,
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_en,
   input  logic              slow,
   input  logic              mode,
   input  logic              restart,
   output logic [BEAT_W-1:0] ibeat,
   output logic              beat_tick,
   output logic              playing,
   output logic              done
);

   localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LEN - 1);

   seq_state_t        state;
   seq_state_t        state_nxt;
   logic [BEAT_W-1:0] ibeat_nxt;
   logic              hit;
   logic              run;
   logic              clr;
   logic              advance;
   logic              at_last;
   logic              end_hit;

   assign run     = (state == PLAY) && play_en;
   assign advance = run && hit && !restart && !mode;
   assign at_last = (ibeat == LAST);

`ifdef BEAT_SEQ_LOOP_EN
   assign end_hit = 1'b0;
`else
   // The final boundary clears the prescaler instead of pulsing beat_tick.
   assign end_hit = advance && at_last;
`endif

   assign clr = restart || mode || (state == IDLE) || (state == DONE) || end_hit;

   beat_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .clr   (clr),
      .slow  (slow),
      .hit   (hit),
      .tick  (beat_tick)
   );

   always_comb begin
      state_nxt = state;
      ibeat_nxt = ibeat;
      if (restart) begin
         ibeat_nxt = '0;
         state_nxt = (play_en && !mode) ? PLAY : IDLE;
      end else if (mode) begin
         ibeat_nxt = '0;
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               ibeat_nxt = '0;
               if (play_en) state_nxt = PLAY;
            end
            PLAY: begin
               if (!play_en) begin
                  state_nxt = PAUSE;
               end else if (hit) begin
                  if (!at_last) begin
                     ibeat_nxt = ibeat + 1'b1;
                  end else begin
`ifdef BEAT_SEQ_LOOP_EN
                     ibeat_nxt = '0;
`else
                     state_nxt = DONE;
`endif
                  end
               end
            end
            PAUSE: begin
               if (play_en) state_nxt = PLAY;
            end
            DONE: begin
               ibeat_nxt = LAST;
            end
            default: begin
               state_nxt = IDLE;
               ibeat_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ibeat   <= '0;
         playing <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         ibeat   <= ibeat_nxt;
         playing <= (state_nxt == PLAY);
`ifdef BEAT_SEQ_LOOP_EN
         done    <= 1'b0;
`else
         done    <= (state_nxt == DONE);
`endif
      end
   end

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with LEN=4, TICK_DIV=3.
module tb_beat_sequencer;

   localparam int LEN      = 4;
   localparam int TICK_DIV = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        play_en = 1'b0;
   logic        slow = 1'b0;
   logic        mode = 1'b0;
   logic        restart = 1'b0;
   logic [11:0] ibeat;
   logic        beat_tick;
   logic        playing;
   logic        done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        pe;
      logic        md;
      logic        rs;
      logic [11:0] ib;
      logic        tk;
      logic        pl;
      logic        dn;
   } vec_t;

   vec_t vecs[$];

   beat_sequencer #(
      .LEN      (LEN),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .play_en   (play_en),
      .slow      (slow),
      .mode      (mode),
      .restart   (restart),
      .ibeat     (ibeat),
      .beat_tick (beat_tick),
      .playing   (playing),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] outs();
      return {ibeat, beat_tick, playing, done};
   endfunction

   task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got{ibeat,tick,play,done}=%h want=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic pe, input logic md, input logic rs, input int ib,
                      input logic tk, input logic pl, input logic dn);
      vec_t v;
      v.pe = pe; v.md = md; v.rs = rs; v.ib = 12'(ib);
      v.tk = tk; v.pl = pl; v.dn = dn;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // n-1 quiet cycles, then a tick carrying exp_ib on cycle n.
   task automatic tick_after(input string name, input int n, input int exp_ib);
      for (int i = 1; i <= n; i++) begin
         step();
         if (i < n) chk($sformatf("%s_quiet%0d", name, i), {15'(beat_tick)}, 15'd0);
         else       chk($sformatf("%s_tick", name), {ibeat, beat_tick}, {12'(exp_ib), 1'b1});
      end
   endtask

   task automatic quiet(input string name, input int n);
      for (int i = 1; i <= n; i++) begin
         step();
         chk($sformatf("%s_%0d", name, i), {15'(beat_tick)}, 15'd0);
      end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
   endtask

   task automatic wait_end();
      bit ok = 1'b0;
      int n = 0;
      while (!ok && n < 40) begin
         step();
         n++;
`ifdef BEAT_SEQ_LOOP_EN
         ok = (ibeat == 12'(LEN - 1));
`else
         ok = done;
`endif
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wait_end got=timeout want=end_of_song");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Normal play from IDLE through the end of the song.
      add(0,0,0, 0,0,0,0);
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 1,1,1,0);
      add(1,0,0, 1,0,1,0);
      add(1,0,0, 1,0,1,0);
      add(1,0,0, 2,1,1,0);
      add(1,0,0, 2,0,1,0);
      add(1,0,0, 2,0,1,0);
      add(1,0,0, 3,1,1,0);
      add(1,0,0, 3,0,1,0);
      add(1,0,0, 3,0,1,0);
`ifdef BEAT_SEQ_LOOP_EN
      add(1,0,0, 0,1,1,0);
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 1,1,1,0);
`else
      add(1,0,0, 3,0,0,1);
      add(1,0,0, 3,0,0,1);
      add(1,0,0, 3,0,0,1);
      add(1,0,0, 3,0,0,1);
`endif
      // Mode parks the sequencer; restart+mode together lands in IDLE.
      add(1,1,0, 0,0,0,0);
      add(1,1,0, 0,0,0,0);
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 0,0,1,0);
      add(1,0,0, 1,1,1,0);
      add(1,1,1, 0,0,0,0);
      add(0,0,0, 0,0,0,0);

      reset = 1'b1;
      step();
      chk("reset_hold", outs(), 15'd0);
      reset = 1'b0;
      step();
      chk("reset_release", outs(), 15'd0);

      foreach (vecs[i]) begin
         play_en = vecs[i].pe;
         mode    = vecs[i].md;
         restart = vecs[i].rs;
         step();
         chk($sformatf("vec%0d", i), outs(),
             {vecs[i].ib, vecs[i].tk, vecs[i].pl, vecs[i].dn});
      end
      mode    = 1'b0;
      restart = 1'b0;

      // Restart at end of song.
      play_en = 1'b1;
      wait_end();
      pulse_restart();
      chk("restart_state", outs(), {12'd0, 1'b0, 1'b1, 1'b0});
      tick_after("restart", 3, 1);

      // Slow playback, then drop slow with cnt=4.
      slow = 1'b1;
      pulse_restart();
      chk("slow_entry", outs(), {12'd0, 1'b0, 1'b1, 1'b0});
      tick_after("slow1", 6, 1);
      quiet("slow_cnt", 4);
      slow = 1'b0;
      tick_after("fast_now", 1, 2);
      tick_after("fast_next", 3, 3);

      // Pause two cycles into a beat.
      pulse_restart();
      tick_after("pre_pause", 3, 1);
      quiet("into_beat", 2);
      play_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("pause%0d", i), outs(), {12'd1, 1'b0, 1'b0, 1'b0});
      end
      play_en = 1'b1;
      step();
      chk("resume", outs(), {12'd1, 1'b0, 1'b1, 1'b0});
      tick_after("resume", 1, 2);

      // Asynchronous reset between edges.
      pulse_restart();
      tick_after("pre_reset", 3, 1);
      quiet("mid_beat", 1);
      #2 reset = 1'b1;
      #1 chk("async_reset", outs(), 15'd0);
      step();
      chk("reset_held", outs(), 15'd0);
      #2 reset = 1'b0;
      step();
      chk("post_reset_play", outs(), {12'd0, 1'b0, 1'b1, 1'b0});
      tick_after("post_reset", 3, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
